vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- HOR_TOTAL, 1056, pixels per line
- HOR_ACTIVE, 800, visible pixels per line
- HOR_SYNC_START, 840, first hcount with hsync asserted
- HOR_SYNC_END, 968, first hcount after hsync
- VER_TOTAL, 628, lines per frame
- VER_ACTIVE, 600, visible lines per frame
- VER_SYNC_START, 601, first vcount with vsync asserted
- VER_SYNC_END, 605, first vcount after vsync
REQ-002 One clock; reset is asynchronous and active-low. Ports, one per line (name, direction, width, meaning):
- clk, in, 1, pixel clock (40 MHz nominal)
- rst_n, in, 1, asynchronous active-low reset
- en, in, 1, count enable; low freezes all state
- hcount, out, 11, horizontal pixel index
- vcount, out, 11, vertical line index
- hsync, out, 1, horizontal sync, active high
- vsync, out, 1, vertical sync, active high
- hblnk, out, 1, horizontal blanking
- vblnk, out, 1, vertical blanking
- sof, out, 1, start-of-frame strobe
- frame_cnt, out, 16, completed-frame counter

Function
REQ-003 hcount SHALL increment by 1 on each clk edge with en=1 and wrap from HOR_TOTAL-1 to 0.
REQ-004 vcount SHALL increment only on the edge where hcount wraps, and SHALL wrap from VER_TOTAL-1 to 0 when both counters are at their maximum on the same edge.
REQ-005 All outputs SHALL be registered and decoded from the next-state counter values, so every output is aligned with the hcount/vcount shown in the same cycle (zero relative latency).
REQ-006 hsync SHALL be 1 exactly when HOR_SYNC_START <= hcount < HOR_SYNC_END.
REQ-007 vsync SHALL be 1 exactly when VER_SYNC_START <= vcount < VER_SYNC_END, for whole lines (hcount 0..HOR_TOTAL-1).
REQ-008 hblnk SHALL be 1 exactly when hcount >= HOR_ACTIVE.
REQ-009 vblnk SHALL be 1 exactly when vcount >= VER_ACTIVE.
REQ-010 sof SHALL be 1 for exactly one cycle, when hcount=0 and vcount=0 follow a wrap; it SHALL NOT be asserted in the first cycle after reset release.
REQ-011 frame_cnt SHALL increment by 1 modulo 2^16 on each vcount wrap, and SHALL roll over from 16'hFFFF to 0.
REQ-012 With en=0, every register SHALL hold its value; sof SHALL be held at 0 during en=0, and the pending strobe SHALL assert on the first enabled cycle at frame start.
REQ-013 Counter arithmetic SHALL be unsigned at 11 bits; parameters SHALL satisfy ACTIVE < SYNC_START < SYNC_END <= TOTAL <= 2048.

Reset
REQ-014 While rst_n=0, all of the following SHALL be forced to 0 immediately (asynchronously): hcount, vcount, hsync, vsync, hblnk, vblnk, sof and frame_cnt.
REQ-015 Release of rst_n SHALL be honoured on the next clk edge; the first enabled edge after release SHALL produce hcount=1, vcount=0.
REQ-016 Assertion of rst_n mid-frame SHALL abandon the frame; frame_cnt SHALL NOT increment.

Structure
REQ-017 The timing constants SHALL live in the shared package vga_pkg, which is the source of the parameter defaults.
REQ-018 A packed struct vga_tim_t (hcount, vcount, hsync, vsync, hblnk, vblnk) SHALL be defined in vga_pkg for downstream draw stages.
REQ-019 The block SHALL be implemented as a single module with no sub-module; the counter and decode logic is too small to split.

Verification
REQ-020 Reset held for 5 cycles, then en=1: all outputs are 0 during reset, and the first edge after release gives hcount=1.
REQ-021 Free run: consecutive hsync rising edges are 1056 clk apart, each hsync pulse is 128 clk wide, and hblnk is high for 256 clk per line.
REQ-022 Free run: consecutive vsync negedges are 1056*628 = 663168 clk apart (16.5792 ms at 25 ns), each vsync pulse is 4 lines wide, and vblnk is high for 28 lines.
REQ-023 Wrap check: at hcount=1055, vcount=627, the next edge gives hcount=0, vcount=0, sof=1 and frame_cnt+1.
REQ-024 Drive en=0 for 100 cycles mid-line: hcount, vcount and all syncs are unchanged, and counting resumes from the same value.
REQ-025 Pulse rst_n low at vcount=300: outputs go to 0 asynchronously before the next clk edge, and frame_cnt stays 0.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg -- shared VGA timing definitions.
//
// Holds the default 800x600 @ 60 Hz timing (40 MHz pixel clock), the counter
// type, and the timing bundle handed to downstream draw stages. vga_timing
// takes its parameter defaults from the constants below, so a different video
// mode is selected either here or by overriding the module parameters.
//
// Timing constants must satisfy ACTIVE < SYNC_START < SYNC_END <= TOTAL <= 2048
// on each axis. Counters are 11-bit unsigned.
// -----------------------------------------------------------------------------
package vga_pkg;

  // Counter width: 11 bits covers totals up to 2048.
  localparam int unsigned VGA_CNT_W = 11;

  // Horizontal timing, in pixel clocks.
  localparam int unsigned VGA_HOR_TOTAL      = 1056;
  localparam int unsigned VGA_HOR_ACTIVE     = 800;
  localparam int unsigned VGA_HOR_SYNC_START = 840;
  localparam int unsigned VGA_HOR_SYNC_END   = 968;

  // Vertical timing, in lines.
  localparam int unsigned VGA_VER_TOTAL      = 628;
  localparam int unsigned VGA_VER_ACTIVE     = 600;
  localparam int unsigned VGA_VER_SYNC_START = 601;
  localparam int unsigned VGA_VER_SYNC_END   = 605;

  // Width of the completed-frame counter.
  localparam int unsigned VGA_FRAME_W = 16;

  typedef logic [VGA_CNT_W-1:0]   vga_cnt_t;
  typedef logic [VGA_FRAME_W-1:0] vga_frame_t;

  // Per-pixel timing bundle for draw stages: position plus sync/blank flags,
  // all aligned to the same pixel.
  typedef struct packed {
    vga_cnt_t hcount;
    vga_cnt_t vcount;
    logic     hsync;
    logic     vsync;
    logic     hblnk;
    logic     vblnk;
  } vga_tim_t;

  // True when lo <= cnt < hi. The comparison is done at 32 bits so that an
  // upper bound of 2048 (one past the largest 11-bit count) still works.
  function automatic logic vga_in_window(input vga_cnt_t    cnt,
                                         input int unsigned lo,
                                         input int unsigned hi);
    return (32'(cnt) >= lo) && (32'(cnt) < hi);
  endfunction

  // True when cnt >= lo, evaluated at 32 bits.
  function automatic logic vga_at_or_above(input vga_cnt_t    cnt,
                                           input int unsigned lo);
    return 32'(cnt) >= lo;
  endfunction

  // Largest count value for a given total (the wrap point).
  function automatic vga_cnt_t vga_last(input int unsigned total);
    return vga_cnt_t'(total - 1);
  endfunction

endpackage : vga_pkg

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing -- VGA raster counter and sync/blank generator.
//
// A horizontal pixel counter and a vertical line counter walk the raster.
// Every output is a flop loaded from a decode of the *next* counter values,
// so sync, blank and sof always describe the hcount/vcount shown in the same
// cycle (zero relative latency, no output glitches).
//
// Ports
//   clk        in   1   pixel clock (40 MHz nominal)
//   rst_n      in   1   asynchronous active-low reset; clears every output
//   en         in   1   count enable; low freezes all state and holds sof at 0
//   hcount     out  11  horizontal pixel index, 0 .. HOR_TOTAL-1
//   vcount     out  11  vertical line index,    0 .. VER_TOTAL-1
//   hsync      out  1   high while HOR_SYNC_START <= hcount < HOR_SYNC_END
//   vsync      out  1   high while VER_SYNC_START <= vcount < VER_SYNC_END
//   hblnk      out  1   high while hcount >= HOR_ACTIVE
//   vblnk      out  1   high while vcount >= VER_ACTIVE
//   sof        out  1   one-cycle strobe on the pixel (0,0) reached by a wrap
//   frame_cnt  out  16  completed frames, modulo 2^16
//
// Reset leaves the raster at (0,0) with sof low: the frame that starts after
// reset has not followed a wrap, so it is not flagged. The first enabled edge
// after release therefore shows hcount=1, vcount=0.
// -----------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned HOR_TOTAL      = VGA_HOR_TOTAL,
  parameter int unsigned HOR_ACTIVE     = VGA_HOR_ACTIVE,
  parameter int unsigned HOR_SYNC_START = VGA_HOR_SYNC_START,
  parameter int unsigned HOR_SYNC_END   = VGA_HOR_SYNC_END,
  parameter int unsigned VER_TOTAL      = VGA_VER_TOTAL,
  parameter int unsigned VER_ACTIVE     = VGA_VER_ACTIVE,
  parameter int unsigned VER_SYNC_START = VGA_VER_SYNC_START,
  parameter int unsigned VER_SYNC_END   = VGA_VER_SYNC_END
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
  output logic        sof,
  output logic [15:0] frame_cnt
);

  // Wrap points of the two counters.
  localparam vga_cnt_t H_LAST = vga_last(HOR_TOTAL);
  localparam vga_cnt_t V_LAST = vga_last(VER_TOTAL);

  // Registered timing bundle (counters + sync/blank), strobe and frame count.
  vga_tim_t   tim_q,       tim_d;
  logic       sof_q,       sof_d;
  vga_frame_t frame_cnt_q, frame_cnt_d;

  // End-of-line and end-of-frame, taken from the current counter values.
  logic h_wrap;
  logic v_wrap;

  assign h_wrap = (tim_q.hcount == H_LAST);
  assign v_wrap = h_wrap && (tim_q.vcount == V_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic: advance the counters, then decode the flags from the
  // advanced values so the registered flags line up with the registered
  // counters.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    tim_d       = tim_q;
    frame_cnt_d = frame_cnt_q;
    sof_d       = 1'b0;

    if (en) begin
      tim_d.hcount = h_wrap ? '0 : tim_q.hcount + vga_cnt_t'(1);

      // Lines advance only at the end of a line; the frame ends when both
      // counters sit at their maximum on the same edge.
      if (h_wrap) begin
        tim_d.vcount = v_wrap ? '0 : tim_q.vcount + vga_cnt_t'(1);
      end

      // The wrap edge lands on pixel (0,0) of the new frame, so the strobe
      // is raised here and shows up with that pixel. A frozen cycle keeps
      // the default of 0, so the strobe lasts one enabled cycle only.
      if (v_wrap) begin
        frame_cnt_d = frame_cnt_q + vga_frame_t'(1);
        sof_d       = 1'b1;
      end
    end

    // Decode from the next-state counters. With en low the counters hold,
    // so these recompute to the values already registered.
    tim_d.hsync = vga_in_window(tim_d.hcount, HOR_SYNC_START, HOR_SYNC_END);
    tim_d.vsync = vga_in_window(tim_d.vcount, VER_SYNC_START, VER_SYNC_END);
    tim_d.hblnk = vga_at_or_above(tim_d.hcount, HOR_ACTIVE);
    tim_d.vblnk = vga_at_or_above(tim_d.vcount, VER_ACTIVE);
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset clears everything asynchronously; (0,0) decodes to
  // all-flags-low for any legal timing, so the cleared flags are consistent
  // with the cleared counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tim_q       <= '0;
      sof_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge inputs regardless of statement order.
      tim_q       <= tim_d;
      sof_q       <= sof_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from the flops.
  // ---------------------------------------------------------------------------
  assign hcount    = tim_q.hcount;
  assign vcount    = tim_q.vcount;
  assign hsync     = tim_q.hsync;
  assign vsync     = tim_q.vsync;
  assign hblnk     = tim_q.hblnk;
  assign vblnk     = tim_q.vblnk;
  assign sof       = sof_q;
  assign frame_cnt = frame_cnt_q;

endmodule : vga_timing

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing -- self-checking bench for vga_timing.
//
// The DUT runs with a reduced raster (40 x 20) so several whole frames fit in
// a short run; all timing relations are the same as in the full-size mode.
// The reference model counts enabled edges since reset and derives the raster
// position, flags and frame count from that number with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_vga_timing;

  localparam int HT    = 40;   // pixels per line
  localparam int HA    = 24;   // visible pixels
  localparam int HSS   = 28;   // hsync start
  localparam int HSE   = 34;   // hsync end
  localparam int VT    = 20;   // lines per frame
  localparam int VA    = 12;   // visible lines
  localparam int VSS   = 13;   // vsync start
  localparam int VSE   = 15;   // vsync end
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        sof;
  logic [15:0] frame_cnt;

  vga_timing #(
    .HOR_TOTAL     (HT),
    .HOR_ACTIVE    (HA),
    .HOR_SYNC_START(HSS),
    .HOR_SYNC_END  (HSE),
    .VER_TOTAL     (VT),
    .VER_ACTIVE    (VA),
    .VER_SYNC_START(VSS),
    .VER_SYNC_END  (VSE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .hcount   (hcount),
    .vcount   (vcount),
    .hsync    (hsync),
    .vsync    (vsync),
    .hblnk    (hblnk),
    .vblnk    (vblnk),
    .sof      (sof),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Observed outputs as one vector: {hcount, vcount, hsync, vsync, hblnk,
  // vblnk, sof, frame_cnt}.
  logic [42:0] act_vec;
  assign act_vec = {hcount, vcount, hsync, vsync, hblnk, vblnk, sof, frame_cnt};

  // Reference model state: enabled edges since reset, and the strobe flag.
  int unsigned t;
  bit          sof_m;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [42:0] exp_vec();
    int h;
    int v;
    h = int'(t % HT);
    v = int'((t / HT) % VT);
    return {11'(h), 11'(v),
            (h >= HSS) && (h < HSE),
            (v >= VSS) && (v < VSE),
            h >= HA,
            v >= VA,
            sof_m,
            16'(t / FRAME)};
  endfunction

  // One clock: drive en, take the edge, sample 1 ns later, advance the model.
  task automatic step(input logic en_v);
    en = en_v;
    @(posedge clk);
    #1;
    if (en_v) t++;
    sof_m = en_v && (t % FRAME == 0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [42:0] e;
    rst_n = 1'b0;
    en    = 1'b1;
    t     = 0;
    sof_m = 1'b0;
    #1;
    e = exp_vec();
    n_total++;
    if (act_vec !== e) $display("FAIL reset_async_at_t0: actual %h required %h", act_vec, e);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (act_vec !== 43'd0) $display("FAIL reset_hold cycle %0d: actual %h required 0", i, act_vec);
      else n_pass++;
    end
    rst_n = 1'b1;
    step(1'b1);
    n_total++;
    if (hcount !== 11'd1 || vcount !== 11'd0 || sof !== 1'b0)
      $display("FAIL reset_first_edge: actual h=%0d v=%0d sof=%b required h=1 v=0 sof=0",
               hcount, vcount, sof);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  // Continuous run: every cycle against the model, plus period/width
  // measurements of the sync and blank signals.
  task automatic test_free_run();
    logic [42:0] e;
    logic hs_p, hb_p, vs_p, vb_p;
    int   hs_rise = -1, hs_len = 0, hb_len = 0, vs_fall = -1, vs_len = 0, vb_len = 0;
    bit   hs_seen = 0, hb_seen = 0, vs_seen = 0, vb_seen = 0;
    int   n_hs_per = 0, n_vs_per = 0;
    hs_p = hsync; hb_p = hblnk; vs_p = vsync; vb_p = vblnk;
    for (int c = 0; c < 3 * FRAME; c++) begin
      step(1'b1);
      e = exp_vec();
      n_total++;
      if (act_vec !== e) $display("FAIL free_run t=%0d: actual %h required %h", t, act_vec, e);
      else n_pass++;

      if (hsync && !hs_p) begin
        if (hs_rise >= 0) begin
          n_hs_per++;
          n_total++;
          if (c - hs_rise !== HT) $display("FAIL hsync_period: actual %0d required %0d", c - hs_rise, HT);
          else n_pass++;
        end
        hs_rise = c;
        hs_seen = 1;
        hs_len  = 0;
      end
      if (hsync) hs_len++;
      if (!hsync && hs_p && hs_seen) begin
        n_total++;
        if (hs_len !== HSE - HSS) $display("FAIL hsync_width: actual %0d required %0d", hs_len, HSE - HSS);
        else n_pass++;
      end

      if (hblnk && !hb_p) begin hb_seen = 1; hb_len = 0; end
      if (hblnk) hb_len++;
      if (!hblnk && hb_p && hb_seen) begin
        n_total++;
        if (hb_len !== HT - HA) $display("FAIL hblnk_width: actual %0d required %0d", hb_len, HT - HA);
        else n_pass++;
      end

      if (vsync && !vs_p) begin vs_seen = 1; vs_len = 0; end
      if (vsync) vs_len++;
      if (!vsync && vs_p) begin
        if (vs_seen) begin
          n_total++;
          if (vs_len !== (VSE - VSS) * HT)
            $display("FAIL vsync_width: actual %0d required %0d", vs_len, (VSE - VSS) * HT);
          else n_pass++;
        end
        if (vs_fall >= 0) begin
          n_vs_per++;
          n_total++;
          if (c - vs_fall !== FRAME) $display("FAIL vsync_period: actual %0d required %0d", c - vs_fall, FRAME);
          else n_pass++;
        end
        vs_fall = c;
      end

      if (vblnk && !vb_p) begin vb_seen = 1; vb_len = 0; end
      if (vblnk) vb_len++;
      if (!vblnk && vb_p && vb_seen) begin
        n_total++;
        if (vb_len !== (VT - VA) * HT)
          $display("FAIL vblnk_width: actual %0d required %0d", vb_len, (VT - VA) * HT);
        else n_pass++;
      end

      hs_p = hsync; hb_p = hblnk; vs_p = vsync; vb_p = vblnk;
    end
    // Missing edges would otherwise leave the period checks silently unused.
    n_total++;
    if (n_hs_per < 50 || n_vs_per < 1)
      $display("FAIL sync_edges_seen: actual hs=%0d vs=%0d required hs>=50 vs>=1", n_hs_per, n_vs_per);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap();
    int    guard = 0;
    logic [15:0] fc_before;
    while ((t % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
      step(1'b1);
      guard++;
    end
    n_total++;
    if (hcount !== 11'(HT - 1) || vcount !== 11'(VT - 1))
      $display("FAIL wrap_pre: actual h=%0d v=%0d required h=%0d v=%0d", hcount, vcount, HT - 1, VT - 1);
    else n_pass++;
    fc_before = 16'(t / FRAME);
    step(1'b1);
    n_total++;
    if (hcount !== 11'd0 || vcount !== 11'd0 || sof !== 1'b1 || frame_cnt !== fc_before + 16'd1)
      $display("FAIL wrap_edge: actual h=%0d v=%0d sof=%b fc=%0d required h=0 v=0 sof=1 fc=%0d",
               hcount, vcount, sof, frame_cnt, fc_before + 16'd1);
    else n_pass++;
    step(1'b1);
    n_total++;
    if (sof !== 1'b0) $display("FAIL sof_one_cycle: actual %b required 0", sof);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_en_hold();
    logic [42:0] e;
    int guard = 0;
    // Park inside the hsync pulse so a held sync level is exercised.
    while ((t % HT) != HSS + 2 && guard < 2 * HT) begin
      step(1'b1);
      guard++;
    end
    for (int i = 0; i < 100; i++) begin
      step(1'b0);
      e = exp_vec();
      n_total++;
      if (act_vec !== e) $display("FAIL en_hold cycle %0d: actual %h required %h", i, act_vec, e);
      else n_pass++;
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      e = exp_vec();
      n_total++;
      if (act_vec !== e) $display("FAIL en_resume cycle %0d: actual %h required %h", i, act_vec, e);
      else n_pass++;
    end
    // Freeze right on a frame start: the strobe drops while frozen.
    guard = 0;
    while ((t % FRAME) != 0 && guard < 2 * FRAME) begin
      step(1'b1);
      guard++;
    end
    n_total++;
    if (sof !== 1'b1) $display("FAIL en_sof_at_start: actual %b required 1", sof);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      e = exp_vec();
      n_total++;
      if (act_vec !== e) $display("FAIL en_sof_frozen cycle %0d: actual %h required %h", i, act_vec, e);
      else n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random_enable();
    logic [42:0] e;
    for (int i = 0; i < 2000; i++) begin
      step(logic'($urandom_range(0, 3) != 0));
      e = exp_vec();
      n_total++;
      if (act_vec !== e) $display("FAIL random_en t=%0d: actual %h required %h", t, act_vec, e);
      else n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    logic [42:0] e;
    int guard = 0;
    while ((t % FRAME) != (VT / 2) * HT + 7 && guard < 2 * FRAME) begin
      step(1'b1);
      guard++;
    end
    n_total++;
    if (frame_cnt === 16'd0) $display("FAIL areset_precond: actual fc=0 required nonzero");
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    t     = 0;
    sof_m = 1'b0;
    n_total++;
    if (act_vec !== 43'd0) $display("FAIL areset_immediate: actual %h required 0", act_vec);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < FRAME - 10; i++) begin
      step(1'b1);
      e = exp_vec();
      n_total++;
      if (act_vec !== e || frame_cnt !== 16'd0)
        $display("FAIL areset_after t=%0d: actual %h required %h", t, act_vec, e);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    test_reset();
    test_free_run();
    test_wrap();
    test_en_hold();
    test_random_enable();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_vga_timing
